// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : clkdiv_pkg
//  Description : Shared types and constants for the multi-channel clock
//                divider (output mode encoding, minimum legal divisor).
//  Revision    : 1.0  initial release
// ============================================================================
package clkdiv_pkg;

    // Output shape of one channel.
    typedef enum logic {
        CLKDIV_PULSE  = 1'b0,   // clk_out is a 1-cycle pulse, identical to tick
        CLKDIV_SQUARE = 1'b1    // clk_out is ~50% duty, high half rounded up
    } clkdiv_mode_e;

    // Smallest divisor that still produces a toggling output.
    localparam int MIN_DIV = 2;

endpackage : clkdiv_pkg
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_channel
//  Description : One runtime-programmable divider channel. Holds the period
//                counter, the divisor in force and a pending divisor that is
//                only applied on a period boundary so the output never glitches.
//  Ports       : clk_in     - source clock (rising edge)
//                reset_n    - asynchronous active-low reset
//                enable     - run enable
//                mode       - PULSE / SQUARE output shape
//                div_load   - 1-cycle strobe capturing div_value
//                div_value  - requested divisor
//                clk_out    - divided output (registered)
//                tick       - 1-cycle pulse at the start of each period
//                active_div - divisor currently in force
//                load_err   - 1-cycle pulse after a load of 0 or 1
//  Revision    : 1.0  initial release
// ============================================================================
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              enable,
    input  clkdiv_mode_e      mode,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_value,
    output logic              clk_out,
    output logic              tick,
    output logic [DIV_W-1:0]  active_div,
    output logic              load_err
);

    localparam logic [DIV_W-1:0] c_MIN_DIV     = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] c_DEFAULT_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_ONE         = DIV_W'(1);

    // Architectural state
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_load_err;

    // Next-state values
    logic [DIV_W-1:0] w_load_val;
    logic             w_load_clamp;
    logic             w_wrap;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_pend_nxt;
    logic             w_pend_vld_nxt;
    logic             w_tick_nxt;
    logic [DIV_W-1:0] w_high_len;
    logic             w_clk_nxt;

    // Divisors below the minimum are stored as the minimum and flagged.
    assign w_load_clamp = (div_value < c_MIN_DIV);
    assign w_load_val   = w_load_clamp ? c_MIN_DIV : div_value;

    // r_div is never below 2, so r_div-1 cannot underflow.
    assign w_wrap = (r_cnt == (r_div - c_ONE));

    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_div_nxt      = r_div;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_tick_nxt     = 1'b0;

        if (!enable) begin
            // Idle channel: nothing is in flight, so a new divisor (fresh load
            // or one left pending from before the disable) is taken at once.
            // Parking the count at D-1 makes the first enabled edge a wrap.
            if (div_load) begin
                w_div_nxt = w_load_val;
            end else if (r_pend_vld) begin
                w_div_nxt = r_pend;
            end
            w_pend_vld_nxt = 1'b0;
            w_cnt_nxt      = w_div_nxt - c_ONE;
        end else if (w_wrap) begin
            // Period boundary: the only point where the divisor may change.
            // A load arriving on this very edge wins over an older pending one.
            w_cnt_nxt  = '0;
            w_tick_nxt = 1'b1;
            if (div_load) begin
                w_div_nxt = w_load_val;
            end else if (r_pend_vld) begin
                w_div_nxt = r_pend;
            end
            w_pend_vld_nxt = 1'b0;
        end else begin
            w_cnt_nxt = r_cnt + c_ONE;
            if (div_load) begin
                w_pend_nxt     = w_load_val;
                w_pend_vld_nxt = 1'b1;
            end
        end
    end

    // High phase is the rounded-up half, so odd divisors spend one extra
    // cycle high (D=5 -> 3 high, 2 low).
    assign w_high_len = w_div_nxt - (w_div_nxt >> 1);

    always_comb begin
        w_clk_nxt = 1'b0;
        if (enable) begin
            if (mode == CLKDIV_SQUARE) begin
                w_clk_nxt = (w_cnt_nxt < w_high_len);
            end else begin
                w_clk_nxt = w_tick_nxt;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= c_DEFAULT_DIV - c_ONE;
            r_div      <= c_DEFAULT_DIV;
            r_pend     <= c_DEFAULT_DIV;
            r_pend_vld <= 1'b0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_div      <= w_div_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_clk_out  <= w_clk_nxt;
            r_tick     <= w_tick_nxt;
            r_load_err <= div_load & w_load_clamp;
        end
    end

    assign clk_out    = r_clk_out;
    assign tick       = r_tick;
    assign active_div = r_div;
    assign load_err   = r_load_err;

endmodule : clkdiv_channel
`default_nettype wire

// File: rtl/multi_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : multi_clock_divider
//  Description : NUM_CH independent, runtime-programmable clock/tick dividers
//                from one source clock. Each channel has its own enable,
//                PULSE/SQUARE mode and glitch-free divisor reload.
//  Ports       : clk_in     - source clock (rising edge)
//                reset_n    - asynchronous active-low reset
//                enable     [NUM_CH]        per-channel run enable
//                mode       [NUM_CH]        0 = PULSE, 1 = SQUARE
//                div_load   [NUM_CH]        1-cycle divisor load strobe
//                div_value  [NUM_CH*DIV_W]  divisors, channel i at [i*DIV_W +: DIV_W]
//                clk_out    [NUM_CH]        divided outputs (registered)
//                tick       [NUM_CH]        period-start pulses (registered)
//                active_div [NUM_CH*DIV_W]  divisor in force per channel
//                load_err   [NUM_CH]        pulse after a clamped load of 0/1
//  Revision    : 1.0  initial release
// ============================================================================
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [NUM_CH-1:0]         mode,
    input  logic [NUM_CH-1:0]         div_load,
    input  logic [NUM_CH*DIV_W-1:0]   div_value,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH*DIV_W-1:0]   active_div,
    output logic [NUM_CH-1:0]         load_err
);

    // Channels share nothing but clock and reset; the top only slices buses.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        clkdiv_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clk_in     (clk_in),
            .reset_n    (reset_n),
            .enable     (enable[gi]),
            .mode       (clkdiv_mode_e'(mode[gi])),
            .div_load   (div_load[gi]),
            .div_value  (div_value[gi*DIV_W +: DIV_W]),
            .clk_out    (clk_out[gi]),
            .tick       (tick[gi]),
            .active_div (active_div[gi*DIV_W +: DIV_W]),
            .load_err   (load_err[gi])
        );
    end : g_ch

endmodule : multi_clock_divider
`default_nettype wire

// File: tb/tb_multi_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_clock_divider
//  Description : Self-checking bench for multi_clock_divider. A per-channel
//                reference model predicts every output at each driven cycle;
//                predictions are queued and compared after the clock edge.
//                Directed checks add period/pattern expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_clock_divider;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 2;

    logic                    clk_in    = 1'b0;
    logic                    reset_n   = 1'b0;
    logic [NUM_CH-1:0]       enable    = '0;
    logic [NUM_CH-1:0]       mode      = '0;
    logic [NUM_CH-1:0]       div_load  = '0;
    logic [NUM_CH*DIV_W-1:0] div_value = '0;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH*DIV_W-1:0] active_div;
    logic [NUM_CH-1:0]       load_err;

    multi_clock_divider #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .div_load   (div_load),
        .div_value  (div_value),
        .clk_out    (clk_out),
        .tick       (tick),
        .active_div (active_div),
        .load_err   (load_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [NUM_CH-1:0]       co;
        logic [NUM_CH-1:0]       tk;
        logic [NUM_CH-1:0]       le;
        logic [NUM_CH*DIV_W-1:0] ad;
    } exp_t;

    exp_t sb_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int m_cnt [NUM_CH];
    int m_div [NUM_CH];
    int m_pend[NUM_CH];
    bit m_pv  [NUM_CH];
    bit m_co  [NUM_CH];
    bit m_tk  [NUM_CH];
    bit m_le  [NUM_CH];

    // Observed tick spacing per channel
    int since[NUM_CH];
    int gap  [NUM_CH];

    logic [9:0]  pat10;
    logic [9:0]  tpat10;
    logic [11:0] pat12;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i]  = DEFAULT_DIV - 1;
            m_div[i]  = DEFAULT_DIV;
            m_pend[i] = 0;
            m_pv[i]   = 1'b0;
            m_co[i]   = 1'b0;
            m_tk[i]   = 1'b0;
            m_le[i]   = 1'b0;
            since[i]  = 0;
            gap[i]    = 0;
        end
        sb_q.delete();
    endtask

    // Predict the state after the coming rising edge from the current inputs.
    task automatic model_edge();
        for (int i = 0; i < NUM_CH; i++) begin
            int dv;
            int lv;
            dv = int'(div_value[i*DIV_W +: DIV_W]);
            lv = (dv < 2) ? 2 : dv;
            m_le[i] = div_load[i] && (dv < 2);
            if (!enable[i]) begin
                if (div_load[i]) m_div[i] = lv;
                else if (m_pv[i]) m_div[i] = m_pend[i];
                m_pv[i]  = 1'b0;
                m_cnt[i] = m_div[i] - 1;
                m_co[i]  = 1'b0;
                m_tk[i]  = 1'b0;
            end else begin
                if (m_cnt[i] == m_div[i] - 1) begin
                    m_cnt[i] = 0;
                    m_tk[i]  = 1'b1;
                    if (div_load[i]) m_div[i] = lv;
                    else if (m_pv[i]) m_div[i] = m_pend[i];
                    m_pv[i] = 1'b0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                    m_tk[i]  = 1'b0;
                    if (div_load[i]) begin
                        m_pend[i] = lv;
                        m_pv[i]   = 1'b1;
                    end
                end
                if (mode[i]) m_co[i] = (m_cnt[i] < (m_div[i] - (m_div[i] / 2)));
                else         m_co[i] = m_tk[i];
            end
        end
    endtask

    // One clock: predict, queue, clock, compare; load strobes last one cycle.
    task automatic step();
        exp_t e;
        exp_t g;
        model_edge();
        for (int i = 0; i < NUM_CH; i++) begin
            e.co[i] = m_co[i];
            e.tk[i] = m_tk[i];
            e.le[i] = m_le[i];
            e.ad[i*DIV_W +: DIV_W] = DIV_W'(m_div[i]);
        end
        sb_q.push_back(e);
        @(posedge clk_in);
        #1;
        g = sb_q.pop_front();
        chk("clk_out",    64'(clk_out),    64'(g.co));
        chk("tick",       64'(tick),       64'(g.tk));
        chk("load_err",   64'(load_err),   64'(g.le));
        chk("active_div", 64'(active_div), 64'(g.ad));
        for (int i = 0; i < NUM_CH; i++) begin
            if (tick[i]) begin
                gap[i]   = since[i];
                since[i] = 1;
            end else begin
                since[i]++;
            end
        end
        div_load = '0;
    endtask

    task automatic wait_tick(input int ch, input int bound);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[ch] && n < bound);
        if (!tick[ch]) chk("tick_timeout", 64'(tick[ch]), 64'd1);
    endtask

    task automatic load(input int ch, input int val);
        div_value[ch*DIV_W +: DIV_W] = DIV_W'(val);
        div_load[ch] = 1'b1;
    endtask

    // Assert reset between edges and check outputs clear before any edge.
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_clk_out",    64'(clk_out),    64'd0);
        chk("rst_tick",       64'(tick),       64'd0);
        chk("rst_load_err",   64'(load_err),   64'd0);
        chk("rst_active_div", 64'(active_div), {4{16'd2}});
        model_reset();
        enable = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk_in);
        chk("por_clk_out",    64'(clk_out),    64'd0);
        chk("por_tick",       64'(tick),       64'd0);
        chk("por_active_div", 64'(active_div), {4{16'd2}});
        reset_n = 1'b1;

        // Ch0 PULSE, default D=2: pulse on first enabled edge, then every 2nd
        enable[0] = 1'b1;
        step();
        chk("t2_first_tick", 64'(tick[0]),    64'd1);
        chk("t2_first_clk",  64'(clk_out[0]), 64'd1);
        step();
        chk("t2_low",        64'(clk_out[0]), 64'd0);
        step();
        chk("t2_second",     64'(clk_out[0]), 64'd1);

        // Ch1 SQUARE, load 5 while disabled, then run
        mode[1] = 1'b1;
        load(1, 5);
        step();
        chk("t3_active5", 64'(active_div[1*DIV_W +: DIV_W]), 64'd5);
        enable[1] = 1'b1;
        pat10  = '0;
        tpat10 = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            pat10  = {pat10[8:0],  clk_out[1]};
            tpat10 = {tpat10[8:0], tick[1]};
        end
        chk("t3_square5", 64'(pat10),  64'(10'b1110011100));
        chk("t3_tick5",   64'(tpat10), 64'(10'b1000010000));
        // Load 6 on the wrap edge: the new period already uses 6
        load(1, 6);
        pat12 = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            pat12 = {pat12[10:0], clk_out[1]};
        end
        chk("t3_square6", 64'(pat12), 64'(12'b111000111000));
        step();
        chk("pre_rst_tick1", 64'(tick[1]), 64'd1);

        // Asynchronous reset mid-cycle while running
        async_reset();

        // Ch2 reload at period boundaries
        load(2, 6);
        step();
        enable[2] = 1'b1;
        step();
        chk("t4_first_tick", 64'(tick[2]), 64'd1);
        step();
        step();
        load(2, 4);
        wait_tick(2, 20);
        chk("t4_gap_old6", 64'(gap[2]), 64'd6);
        wait_tick(2, 20);
        chk("t4_gap_new4", 64'(gap[2]), 64'd4);
        load(2, 4);
        step();
        load(2, 8);
        step();
        wait_tick(2, 20);
        chk("t4_gap_cur4",  64'(gap[2]), 64'd4);
        wait_tick(2, 20);
        chk("t4_last_wins", 64'(gap[2]), 64'd8);
        repeat (7) step();
        load(2, 3);
        wait_tick(2, 20);
        chk("t4_wrap_gap8", 64'(gap[2]), 64'd8);
        chk("t4_wrap_ad3",  64'(active_div[2*DIV_W +: DIV_W]), 64'd3);
        wait_tick(2, 20);
        chk("t4_wrap_gap3", 64'(gap[2]), 64'd3);

        // Clamped loads
        load(3, 7);
        step();
        load(3, 0);
        step();
        chk("t5_err0",  64'(load_err[3]), 64'd1);
        chk("t5_ad0",   64'(active_div[3*DIV_W +: DIV_W]), 64'd2);
        step();
        chk("t5_err_clear", 64'(load_err[3]), 64'd0);
        load(3, 9);
        step();
        load(3, 1);
        step();
        chk("t5_err1",  64'(load_err[3]), 64'd1);
        chk("t5_ad1",   64'(active_div[3*DIV_W +: DIV_W]), 64'd2);
        load(2, 1);
        step();
        chk("t5_err_run", 64'(load_err[2]), 64'd1);
        wait_tick(2, 20);
        wait_tick(2, 20);
        chk("t5_run_clamped", 64'(gap[2]), 64'd2);

        // All channels with distinct divisors/modes
        enable = '0;
        mode   = 4'b0110;
        load(0, 3);
        load(1, 5);
        load(2, 4);
        load(3, 7);
        step();
        enable = 4'b1111;
        repeat (20) step();
        enable[3] = 1'b0;
        step();
        load(3, 6);
        step();
        enable[3] = 1'b1;
        repeat (20) step();
        chk("t6_ch3_ad6", 64'(active_div[3*DIV_W +: DIV_W]), 64'd6);
        wait_tick(0, 20);
        wait_tick(0, 20);
        chk("t6_ch0_gap3", 64'(gap[0]), 64'd3);
        wait_tick(1, 20);
        enable[1] = 1'b0;
        step();
        chk("t6_dis_clk",  64'(clk_out[1]), 64'd0);
        chk("t6_dis_tick", 64'(tick[1]),    64'd0);
        enable[1] = 1'b1;
        step();
        chk("t6_reen_tick", 64'(tick[1]),    64'd1);
        chk("t6_reen_clk",  64'(clk_out[1]), 64'd1);
        repeat (2) step();
        load(2, 9);
        step();
        async_reset();
        chk("t6_rst_ad2", 64'(active_div[2*DIV_W +: DIV_W]), 64'd2);
        enable[2] = 1'b1;
        wait_tick(2, 20);
        wait_tick(2, 20);
        chk("t6_pend_dropped", 64'(gap[2]), 64'd2);

        // Maximum divisor
        enable = '0;
        load(0, 65535);
        step();
        chk("t5_ad_max", 64'(active_div[0 +: DIV_W]), 64'd65535);
        enable[0] = 1'b1;
        wait_tick(0, 10);
        wait_tick(0, 70000);
        chk("t5_gap_max", 64'(gap[0]), 64'd65535);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_multi_clock_divider
`default_nettype wire
